multi_key_dispenser: RTL and testbench

//  Parametrised successor to the single-channel key generator for the RC4 brute-force search.
//  - Hands out candidate keys KEY_LOWER..KEY_UPPER (inclusive) to NUM_CORES decrypt cores.
//  - Uses a round-robin req/grant handshake.
//  - Tracks outstanding keys, stops on the first match, and reports FOUND or EXHAUSTED.
//  - Sits between the top-level controller and the array of decrypt/check cores.

---
 rtl/multi_key_dispenser.sv | 157 +++++++++++++++
 tb/tb_multi_key_dispenser.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_key_dispenser.sv
// Round-robin key dispenser for the RC4 brute-force search: hands keys KEY_LOWER..KEY_UPPER
// to NUM_CORES decrypt cores, tracks keys in flight and stops on the first reported match.
module multi_key_dispenser #(
  parameter int                   KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_LOWER = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_UPPER = 24'h3FFFFF,
  parameter int                   NUM_CORES = 4,
  parameter int                   CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [NUM_CORES-1:0]           req,
  output logic [NUM_CORES-1:0]           grant,
  output logic [NUM_CORES*KEY_WIDTH-1:0] key_out,
  input  logic [NUM_CORES-1:0]           result,
  input  logic [NUM_CORES-1:0]           match,
  output logic                           busy,
  output logic                           found,
  output logic                           exhausted,
  output logic [KEY_WIDTH-1:0]           found_key,
  output logic [CORE_W-1:0]              found_core
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FOUND,
    S_EXHAUSTED
  } state_t;

  state_t                 state, state_nxt;
  logic [KEY_WIDTH:0]     next_key, next_key_nxt;
  logic [NUM_CORES-1:0]   outstanding, outstanding_nxt;
  logic [NUM_CORES-1:0]   grant_nxt;
  logic [CORE_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic [KEY_WIDTH-1:0]   found_key_nxt;
  logic [CORE_W-1:0]      found_core_nxt;

  logic                   active;
  logic [NUM_CORES-1:0]   live;
  logic [NUM_CORES-1:0]   hits;
  logic [NUM_CORES-1:0]   eligible;
  logic                   hit_vld;
  logic [CORE_W-1:0]      hit_idx;
  logic [KEY_WIDTH-1:0]   hit_key;
  logic                   sel_vld;
  logic [CORE_W-1:0]      sel_idx;

  assign active   = (state == S_RUN) || (state == S_DRAIN);
  // Results from cores with nothing in flight are dropped here.
  assign live     = active ? (result & outstanding) : '0;
  assign hits     = live & match;
  assign eligible = req & ~outstanding & ~grant;

  always_comb begin
    hit_vld = 1'b0;
    hit_idx = '0;
    hit_key = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (hits[i]) begin
        hit_vld = 1'b1;
        hit_idx = CORE_W'(i);
        hit_key = key_out[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

  // Rotating search starting at rr_ptr; only constant bit selects on eligible.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!sel_vld && eligible[i] && (((int'(rr_ptr) + k) % NUM_CORES) == i)) begin
          sel_vld = 1'b1;
          sel_idx = CORE_W'(i);
        end
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    next_key_nxt    = next_key;
    outstanding_nxt = outstanding & ~live;
    rr_ptr_nxt      = rr_ptr;
    grant_nxt       = '0;
    found_key_nxt   = found_key;
    found_core_nxt  = found_core;
    case (state)
      S_IDLE, S_FOUND, S_EXHAUSTED: begin
        if (start) begin
          state_nxt       = S_RUN;
          next_key_nxt    = {1'b0, KEY_LOWER};
          outstanding_nxt = '0;
          rr_ptr_nxt      = '0;
          found_key_nxt   = '0;
          found_core_nxt  = '0;
        end
      end
      S_RUN: begin
        if (hit_vld) begin
          state_nxt      = S_FOUND;
          found_key_nxt  = hit_key;
          found_core_nxt = hit_idx;
        end else if (sel_vld) begin
          grant_nxt       = NUM_CORES'(1) << sel_idx;
          outstanding_nxt = outstanding_nxt | grant_nxt;
          rr_ptr_nxt      = (sel_idx == CORE_W'(NUM_CORES - 1)) ? '0 : sel_idx + 1'b1;
          next_key_nxt    = next_key + 1'b1;
          if (next_key == {1'b0, KEY_UPPER}) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (hit_vld) begin
          state_nxt      = S_FOUND;
          found_key_nxt  = hit_key;
          found_core_nxt = hit_idx;
        end else if (outstanding_nxt == '0) begin
          state_nxt = S_EXHAUSTED;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      next_key    <= {1'b0, KEY_LOWER};
      outstanding <= '0;
      rr_ptr      <= '0;
      grant       <= '0;
      key_out     <= {NUM_CORES{KEY_LOWER}};
      found_key   <= '0;
      found_core  <= '0;
    end else begin
      state       <= state_nxt;
      next_key    <= next_key_nxt;
      outstanding <= outstanding_nxt;
      rr_ptr      <= rr_ptr_nxt;
      grant       <= grant_nxt;
      found_key   <= found_key_nxt;
      found_core  <= found_core_nxt;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (grant_nxt[i]) key_out[i*KEY_WIDTH +: KEY_WIDTH] <= next_key[KEY_WIDTH-1:0];
      end
    end
  end

  assign busy      = active;
  assign found     = (state == S_FOUND);
  assign exhausted = (state == S_EXHAUSTED);

endmodule

// File: tb/tb_multi_key_dispenser.sv
// Bench for multi_key_dispenser: a 4-core 0..9 instance checked every cycle against a
// behavioural model, plus a 4-bit-key instance covering the top-of-range boundary.
`timescale 1ns/1ps
module tb_multi_key_dispenser;

  localparam int NA = 4;
  localparam int LO = 0;
  localparam int HI = 9;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_FOUND = 3, PH_EXH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic           start_a = 1'b0;
  logic [3:0]     req_a = '0, result_a = '0, match_a = '0;
  logic [3:0]     grant_a;
  logic [95:0]    key_out_a;
  logic           busy_a, found_a, exhausted_a;
  logic [23:0]    found_key_a;
  logic [1:0]     found_core_a;

  logic           start_b = 1'b0;
  logic [3:0]     req_b = '0, result_b = '0, match_b = '0;
  logic [3:0]     grant_b;
  logic [15:0]    key_out_b;
  logic           busy_b, found_b, exhausted_b;
  logic [3:0]     found_key_b;
  logic [1:0]     found_core_b;

  multi_key_dispenser #(.KEY_WIDTH(24), .KEY_LOWER(24'd0), .KEY_UPPER(24'd9), .NUM_CORES(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .req(req_a), .grant(grant_a), .key_out(key_out_a),
    .result(result_a), .match(match_a), .busy(busy_a), .found(found_a), .exhausted(exhausted_a),
    .found_key(found_key_a), .found_core(found_core_a));

  multi_key_dispenser #(.KEY_WIDTH(4), .KEY_LOWER(4'hE), .KEY_UPPER(4'hF), .NUM_CORES(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .req(req_b), .grant(grant_b), .key_out(key_out_b),
    .result(result_b), .match(match_b), .busy(busy_b), .found(found_b), .exhausted(exhausted_b),
    .found_key(found_key_b), .found_core(found_core_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model of dut_a: search phase, keys in flight and the key each core holds.
  int         m_ph, m_next, m_rr, m_fkey, m_fcore;
  logic [3:0] m_own, m_grant;
  int         m_key [NA];

  task automatic model_reset();
    m_ph = PH_IDLE; m_next = LO; m_rr = 0; m_fkey = 0; m_fcore = 0;
    m_own = '0; m_grant = '0;
    for (int i = 0; i < NA; i++) m_key[i] = LO;
  endtask

  task automatic model_step();
    logic [3:0] live, hits, elig, gr;
    int w, pick, c;
    gr = '0;
    if (m_ph == PH_IDLE || m_ph == PH_FOUND || m_ph == PH_EXH) begin
      if (start_a) begin
        m_ph = PH_RUN; m_next = LO; m_own = '0; m_rr = 0;
      end
    end else begin
      live  = result_a & m_own;
      hits  = live & match_a;
      elig  = req_a & ~m_own & ~m_grant;
      m_own = m_own & ~live;
      if (hits != 0) begin
        w = -1;
        for (int i = NA - 1; i >= 0; i--) if (hits[i]) w = i;
        m_fkey = m_key[w]; m_fcore = w; m_ph = PH_FOUND;
      end else if (m_ph == PH_RUN) begin
        pick = -1;
        for (int k = 0; k < NA; k++) begin
          c = (m_rr + k) % NA;
          if (pick < 0 && elig[c]) pick = c;
        end
        if (pick >= 0) begin
          gr[pick] = 1'b1; m_key[pick] = m_next; m_own[pick] = 1'b1;
          m_rr = (pick + 1) % NA;
          if (m_next == HI) m_ph = PH_DRAIN;
          m_next++;
        end
      end else if (m_own == 0) begin
        m_ph = PH_EXH;
      end
    end
    m_grant = gr;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  always @(negedge clk) begin
    chk("model_grant", 32'(grant_a), 32'(m_grant));
    chk("model_busy", 32'(busy_a), 32'(m_ph == PH_RUN || m_ph == PH_DRAIN));
    chk("model_found", 32'(found_a), 32'(m_ph == PH_FOUND));
    chk("model_exhausted", 32'(exhausted_a), 32'(m_ph == PH_EXH));
    for (int i = 0; i < NA; i++) chk("model_key_out", 32'(key_out_a[i*24 +: 24]), 32'(m_key[i]));
    if (m_ph == PH_FOUND) begin
      chk("model_found_key", 32'(found_key_a), 32'(m_fkey));
      chk("model_found_core", 32'(found_core_a), 32'(m_fcore));
    end
  end

  // Core responder for dut_a: answer 3 cycles after each grant, match only on key tgt.
  bit resp_en = 1'b0;
  int tgt = -1;
  int cnt [NA];
  int rkey [NA];
  int res_count = 0;
  int g_core [$];
  int g_key [$];

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NA; i++) begin
      if (grant_a[i]) begin
        g_core.push_back(i);
        g_key.push_back(int'(key_out_a[i*24 +: 24]));
      end
    end
    if (resp_en) begin
      result_a = '0; match_a = '0;
      for (int i = 0; i < NA; i++) begin
        if (grant_a[i]) begin
          cnt[i] = 3; rkey[i] = int'(key_out_a[i*24 +: 24]);
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 1) begin
            result_a[i] = 1'b1;
            match_a[i]  = (rkey[i] == tgt);
            res_count++;
          end
        end
      end
    end
  endtask

  task automatic clear_resp();
    for (int i = 0; i < NA; i++) begin cnt[i] = 0; rkey[i] = 0; end
    result_a = '0; match_a = '0; res_count = 0;
    g_core.delete(); g_key.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    int n, nb;
    int kb [$];
    clear_resp();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_grant_a", 32'(grant_a), 0);
    for (int i = 0; i < NA; i++) chk("rst_key_out_a", 32'(key_out_a[i*24 +: 24]), 0);
    chk("rst_key_out_b", 32'(key_out_b), 32'h0000EEEE);
    chk("rst_busy_b", 32'(busy_b), 0);

    // Range exhaust with all requests held, plus an ignored start while running.
    resp_en = 1'b1; tgt = -1; clear_resp();
    req_a = 4'hF; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 60 && !exhausted_a; c++) begin
      tick();
      start_a = (c == 4);
    end
    start_a = 1'b0;
    chk("exhaust_reached", 32'(exhausted_a), 1);
    chk("exhaust_after_10_results", 32'(res_count), 10);
    chk("exhaust_grant_count", 32'(g_key.size()), 10);
    for (int k = 0; k < g_key.size() && k < 10; k++) begin
      chk("exhaust_key_order", 32'(g_key[k]), 32'(k));
      chk("exhaust_core_order", 32'(g_core[k]), 32'(k % 4));
    end
    repeat (4) tick();
    chk("exhaust_holds", 32'(exhausted_a), 1);
    chk("exhaust_no_more_grants", 32'(g_key.size()), 10);

    // Restart from EXHAUSTED; core 2 reports a match on key 6.
    clear_resp(); tgt = 6;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 0; c < 60 && !found_a; c++) tick();
    chk("match_found", 32'(found_a), 1);
    chk("match_found_key", 32'(found_key_a), 32'h000006);
    chk("match_found_core", 32'(found_core_a), 2);
    n = g_key.size();
    repeat (4) tick();
    chk("match_no_grant_after", 32'(g_key.size()), 32'(n));
    chk("match_holds", 32'(found_a), 1);

    // Restart from FOUND, then simultaneous matches on cores 1 and 3 with core 0 eligible.
    resp_en = 1'b0; clear_resp();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("restart_clears_found", 32'(found_a), 0);
    chk("restart_busy", 32'(busy_a), 1);
    tick();
    chk("restart_first_key", (g_key.size() > 0) ? 32'(g_key[0]) : 32'hFFFFFFFF, 0);
    tick();
    result_a = 4'b0001;
    tick();
    result_a = 4'b0000;
    tick();
    result_a = 4'b1010; match_a = 4'b1010;
    tick();
    result_a = 4'b0000; match_a = 4'b0000;
    chk("dual_match_no_grant", 32'(grant_a), 0);
    chk("dual_match_found", 32'(found_a), 1);
    chk("dual_match_core", 32'(found_core_a), 1);
    chk("dual_match_key", 32'(found_key_a), 1);
    tick();
    chk("dual_match_grant_count", 32'(g_key.size()), 4);

    // Asynchronous reset in the middle of a run.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    chk("pre_reset_grant", 32'(grant_a), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_grant", 32'(grant_a), 0);
    chk("async_rst_busy", 32'(busy_a), 0);
    chk("async_rst_found", 32'(found_a), 0);
    chk("async_rst_exhausted", 32'(exhausted_a), 0);
    for (int i = 0; i < NA; i++) chk("async_rst_key_out", 32'(key_out_a[i*24 +: 24]), 0);
    chk("async_rst_found_key", 32'(found_key_a), 0);
    chk("async_rst_found_core", 32'(found_core_a), 0);
    tick();
    reset = 1'b0;
    req_a = 4'h0;
    tick();

    // Top-of-range boundary on the 4-bit instance: E and F only, no wrap.
    req_b = 4'hF; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    nb = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      for (int i = 0; i < 4; i++) begin
        if (grant_b[i]) begin
          nb++;
          kb.push_back(int'(key_out_b[i*4 +: 4]));
        end
      end
    end
    chk("bound_grant_count", 32'(nb), 2);
    chk("bound_key0", (kb.size() > 0) ? 32'(kb[0]) : 32'hFFFFFFFF, 32'hE);
    chk("bound_key1", (kb.size() > 1) ? 32'(kb[1]) : 32'hFFFFFFFF, 32'hF);
    chk("bound_drain_busy", 32'(busy_b), 1);
    chk("bound_drain_not_exhausted", 32'(exhausted_b), 0);
    result_b = 4'b0011;
    tick();
    result_b = 4'b0000;
    chk("bound_exhausted", 32'(exhausted_b), 1);
    chk("bound_not_busy", 32'(busy_b), 0);
    chk("bound_not_found", 32'(found_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
